dmem_uart: RTL

Data-side memory and I/O block sitting directly downstream of the single-cycle RISC-V CPU core: it consumes the core's store strobe, address and write data, and returns load data in the same cycle. It contains a word-addressed data RAM and a memory-mapped 8N1 UART transmitter with a small TX FIFO, so programs can print bytes without stalling the core.

---
 rtl/riscv_mmio_pkg.sv | 19 +
 rtl/dmem_uart_tx.sv | 95 +++++++++
 rtl/dmem_uart.sv | 104 ++++++++++
 3 files changed

// File: rtl/riscv_mmio_pkg.sv
// Shared MMIO address map, STATUS bit layout and UART TX state encoding.
// UART_PARITY_EN selects the PARITY state in the UART transmitter.
package riscv_mmio_pkg;

    localparam logic [31:0] TXDATA_ADDR = 32'h1000_0000;
    localparam logic [31:0] STATUS_ADDR = 32'h1000_0004;

    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_OVF   = 3;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

endpackage

// File: rtl/dmem_uart_tx.sv
// UART transmitter: FSM, baud counter and shift register, LSB first.
// UART_PARITY_EN inserts an even parity bit between DATA and STOP.
module uart_tx
    import riscv_mmio_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       valid,
    input  logic [7:0] data,
    output logic       pop,
    output logic       tx,
    output logic       active
);
    localparam int CW = $clog2(CLKS_PER_BIT);

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    shreg;
    logic          tick;

    assign tick   = (cnt == CW'(CLKS_PER_BIT - 1));
    assign active = (state != S_IDLE);
    // A pop at the end of STOP chains frames with no idle gap
    assign pop    = valid &&
                    ((state == S_IDLE) || (state == S_STOP && tick));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
        end else begin
            cnt <= (state == S_IDLE || tick) ? '0 : cnt + 1'b1;
            case (state)
                S_IDLE: begin
                    if (valid) begin
                        shreg <= data;
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (tick) begin
                        idx   <= '0;
                        state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        idx <= idx + 1'b1;
                        if (idx == 3'd7) begin
`ifdef UART_PARITY_EN
                            state <= S_PARITY;
`else
                            state <= S_STOP;
`endif
                        end
                    end
                end
`ifdef UART_PARITY_EN
                S_PARITY: begin
                    if (tick) state <= S_STOP;
                end
`endif
                S_STOP: begin
                    if (tick) begin
                        if (valid) begin
                            shreg <= data;
                            state <= S_START;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        tx = 1'b1;
        case (state)
            S_START: tx = 1'b0;
            S_DATA:  tx = shreg[idx];
`ifdef UART_PARITY_EN
            S_PARITY: tx = ^shreg;
`endif
            default: tx = 1'b1;
        endcase
    end

endmodule

// File: rtl/dmem_uart.sv
// Data RAM plus memory-mapped UART TX with a small FIFO.
// UART_PARITY_EN enables an even parity bit on each frame.
module dmem_uart
    import riscv_mmio_pkg::*;
#(
    parameter int DMEM_WORDS   = 64,
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] Mem_WrAddr,
    input  logic [31:0] Mem_WrData,
    output logic [31:0] ReadData,
    output logic        uart_tx,
    output logic        tx_busy
);
    localparam int AW = $clog2(DMEM_WORDS);
    localparam int FW = $clog2(FIFO_DEPTH);

    logic [31:0]   ram [DMEM_WORDS];
    logic [7:0]    fifo [FIFO_DEPTH];
    logic [FW:0]   wptr;
    logic [FW:0]   rptr;
    logic          full;
    logic          empty;
    logic          ovf;
    logic          pop;
    logic          push_req;
    logic          push_ok;
    logic          active;
    logic          ram_sel;
    logic          tx_sel;
    logic          st_sel;
    logic [AW-1:0] ram_idx;
    logic [31:0]   status;
    logic          unused_addr;

    assign unused_addr = ^Mem_WrAddr[1:0];
    assign ram_sel  = (Mem_WrAddr[31:AW+2] == '0);
    assign tx_sel   = (Mem_WrAddr[31:2] == TXDATA_ADDR[31:2]);
    assign st_sel   = (Mem_WrAddr[31:2] == STATUS_ADDR[31:2]);
    assign ram_idx  = Mem_WrAddr[AW+1:2];

    assign empty    = (wptr == rptr);
    assign full     = (wptr[FW] != rptr[FW]) &&
                      (wptr[FW-1:0] == rptr[FW-1:0]);
    // A full FIFO still takes a byte when a slot frees this same edge
    assign push_req = MemWrite && tx_sel;
    assign push_ok  = push_req && (!full || pop);
    assign tx_busy  = active || !empty;

    always_comb begin
        status           = '0;
        status[ST_FULL]  = full;
        status[ST_EMPTY] = empty;
        status[ST_BUSY]  = tx_busy;
        status[ST_OVF]   = ovf;
    end

    always_comb begin
        ReadData = '0;
        unique case (1'b1)
            ram_sel: ReadData = ram[ram_idx];
            st_sel:  ReadData = status;
            default: ReadData = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (MemWrite && ram_sel) ram[ram_idx] <= Mem_WrData;
    end

    always_ff @(posedge clk) begin
        if (push_ok) fifo[wptr[FW-1:0]] <= Mem_WrData[7:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr <= '0;
            rptr <= '0;
            ovf  <= 1'b0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop)     rptr <= rptr + 1'b1;
            if (push_req && !push_ok)    ovf <= 1'b1;
            else if (MemWrite && st_sel) ovf <= 1'b0;
        end
    end

    uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk    (clk),
        .reset  (reset),
        .valid  (!empty),
        .data   (fifo[rptr[FW-1:0]]),
        .pop    (pop),
        .tx     (uart_tx),
        .active (active)
    );

endmodule
